// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit owning HI/LO: radix-2 Booth MULT and
// restoring DIV, one bit per clock, plus MTHI/MTLO writes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             hi_load,
  input  logic             lo_load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, m;
  logic             qm1, neg_q, neg_r;

  // Booth step: the sum is one bit wider so M = -2^(W-1) cannot overflow.
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] mult_acc_nx, mult_q_nx;

  always_comb begin
    booth_sum = {acc[WIDTH-1], acc};
    case ({q[0], qm1})
      2'b01:   booth_sum = {acc[WIDTH-1], acc} + {m[WIDTH-1], m};
      2'b10:   booth_sum = {acc[WIDTH-1], acc} - {m[WIDTH-1], m};
      default: booth_sum = {acc[WIDTH-1], acc};
    endcase
  end

  assign mult_acc_nx = booth_sum[WIDTH:1];
  assign mult_q_nx   = {booth_sum[0], q[WIDTH-1:1]};

  // Restoring step on magnitudes: acc is the partial remainder, q shifts the
  // dividend out at the top and the quotient bits in at the bottom.
  logic [WIDTH:0]   shifted;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc_nx, div_q_nx, quot_fix, rem_fix;

  assign shifted    = {acc, q[WIDTH-1]};
  assign div_ok     = shifted >= {1'b0, m};
  assign div_acc_nx = div_ok ? (shifted[WIDTH-1:0] - m) : shifted[WIDTH-1:0];
  assign div_q_nx   = {q[WIDTH-2:0], div_ok};
  assign quot_fix   = neg_q ? -div_q_nx : div_q_nx;
  assign rem_fix    = neg_r ? -div_acc_nx : div_acc_nx;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             load_ok;

  assign abs_a   = a[WIDTH-1] ? -a : a;
  assign abs_b   = b[WIDTH-1] ? -b : b;
  assign load_ok = (state == IDLE || state == DONE) && !mult_start && !div_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      qm1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start) begin
            acc      <= '0;
            q        <= b;
            m        <= a;
            qm1      <= 1'b0;
            cnt      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= MULT;
          end else if (div_start) begin
            if (b == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              acc      <= '0;
              q        <= abs_a;
              m        <= abs_b;
              neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r    <= a[WIDTH-1];
              cnt      <= '0;
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= DIV;
            end
          end
        end
        MULT: begin
          acc <= mult_acc_nx;
          q   <= mult_q_nx;
          qm1 <= q[0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi_out <= mult_acc_nx;
            lo_out <= mult_q_nx;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DIV: begin
          acc <= div_acc_nx;
          q   <= div_q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi_out <= rem_fix;
            lo_out <= quot_fix;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_ok && hi_load) hi_out <= a;
      if (load_ok && lo_load) lo_out <= a;
    end
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit that owns the HI and LO registers of the multicycle MIPS datapath. It executes MULT and DIV iteratively, one bit per clock, and also services MTHI/MTLO writes. Its `hi_out`/`lo_out` feed the HI/LO inputs of the register-file write-back selector (MENtoReg codes 0000/0001). The control unit starts an operation and waits on `done`.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `mult_start`  in  1  request signed multiply of `a`×`b`; sampled in IDLE only
- `div_start`  in  1  request signed divide `a`÷`b`; sampled in IDLE only
- `hi_load`  in  1  MTHI: write `a` into HI
- `lo_load`  in  1  MTLO: write `a` into LO
- `a`  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data)
- `b`  in  WIDTH  rt operand (multiplier / divisor)
- `hi_out`  out  WIDTH  HI register
- `lo_out`  out  WIDTH  LO register
- `busy`  out  1  high in MULT and DIV states
- `done`  out  1  one-cycle pulse in DONE state
- `div_zero`  out  1  last accepted DIV had `b`==0; sticky until next accepted start

## Operation
- States: IDLE, MULT, DIV, DONE. A 5-bit iteration counter is used.
- IDLE, `mult_start`=1: latch operands, clear the accumulator, set counter=0, clear `div_zero`, go to MULT. `mult_start` has priority when both starts are high.
- IDLE, `div_start`=1 and `b`≠0: latch |a| and |b|, latch both sign bits, set counter=0, clear `div_zero`, go to DIV.
- IDLE, `div_start`=1 and `b`==0: go directly to DONE, set `div_zero`=1. HI and LO are unchanged.
- Starts in MULT, DIV, or DONE are ignored. They are not queued.
- MULT uses radix-2 Booth over {acc, Q, q₋₁}:
  - {Q[0], q₋₁}=01: acc += M
  - {Q[0], q₋₁}=10: acc −= M
  - Then arithmetic-shift the whole register right by 1.
  - After 32 iterations: HI=acc, LO=Q, giving the full signed 64-bit product.
- DIV uses restoring division on magnitudes, one quotient bit per iteration, for 32 iterations. Sign fix-up happens when writing results:
  - LO = quotient, negated if the operand signs differ. This truncates toward zero.
  - HI = remainder, negated if the dividend is negative.
- DIV overflow case 0x80000000 ÷ 0xFFFFFFFF: the magnitude result wraps to 32 bits, giving LO=0x80000000 and HI=0. No flag is raised.
- `hi_load`/`lo_load`:
  - Take effect in IDLE or DONE only.
  - Ignored in MULT/DIV.
  - Ignored in any cycle where `mult_start` or `div_start` is high.
  - Both loads may be high together; each writes `a` into its own register.
- DONE → IDLE unconditionally after one cycle.

## Timing
- Reset (asynchronous, whenever `reset_n`=0, including mid-operation):
  - state=IDLE, counter=0
  - `hi_out`=`lo_out`=0
  - `busy`=`done`=`div_zero`=0
  - All internal datapath registers are cleared.
- Let E0 be the edge that accepts a start:
  - After E0: `busy`=1.
  - Iterations happen at edges E1..E32.
  - At E32: HI/LO are written, state=DONE.
  - After E32: `busy`=0, `done`=1, and the new `hi_out`/`lo_out` are valid in the same cycle.
  - After E33: state is IDLE and `done`=0.
  - Start-to-done latency is therefore 32 cycles, and the next start can be accepted at E34.
- Divide by zero: after E0, `done`=1 and `div_zero`=1; `busy` never rises. Latency is 1 cycle.
- MTHI/MTLO: the new value is visible on `hi_out`/`lo_out` the cycle after the load edge.
- `hi_out`/`lo_out` are driven straight from registers. They are stable during MULT/DIV and show the previous values until E32.
- Operands `a`/`b` may change freely after E0.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → `busy` high 32 cycles, then `done` for 1 cycle with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT a=b=0x80000000 → HI=0x40000000, LO=0x00000000. Then MULT 0xFFFFFFFF×0xFFFFFFFF → HI=0, LO=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0, `div_zero`=0.
- DIV a=5, b=0 (with HI/LO preloaded via `hi_load`/`lo_load` to 0x11/0x22) → `done` 1 cycle after start, `div_zero`=1, HI=0x11, LO=0x22.
- Start MULT; at iteration 10 pulse `div_start` and `hi_load` (both ignored, result still correct). Start again, pull `reset_n` low mid-op → all outputs 0 immediately and state IDLE; after release a new MULT 3×4 gives LO=12, HI=0.
